// File: rtl/lcd_timing_pkg.sv
// Shared FSM state encoding and default panel timing for the LCD timing generator.
package lcd_timing_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WARMUP = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  localparam int DEF_H_TOTAL     = 1056;
  localparam int DEF_V_TOTAL     = 525;
  localparam int DEF_H_ACTIVE    = 800;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_H_SYNC_W    = 20;
  localparam int DEF_V_SYNC_W    = 10;
  localparam int DEF_H_ACT_START = 211;
  localparam int DEF_V_ACT_START = 23;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;

endpackage

// File: rtl/lcd_pix_div.sv
// Pixel-rate divider: one tick per CLK_DIV clk cycles and a registered dclk,
// low for the first CLK_DIV/2 cycles of each pixel period.
module lcd_pix_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick,
  output logic dclk
);

  localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
  localparam logic [2:0] DIV_HALF = 3'(CLK_DIV / 2);

  logic [2:0] cnt_q, cnt_d;
  logic       dclk_q, dclk_d;

  always_comb begin
    cnt_d = 3'd0;
    if (run) begin
      cnt_d = (cnt_q == DIV_LAST) ? 3'd0 : cnt_q + 3'd1;
    end
    dclk_d = run && (cnt_d >= DIV_HALF);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= 3'd0;
      dclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dclk_q <= dclk_d;
    end
  end

  // cnt_q rests at 0 while stopped, so the tick needs no extra gating.
  assign tick = (cnt_q == DIV_LAST);
  assign dclk = dclk_q;

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: counters, IDLE/WARMUP/RUN FSM and sync/den decode.
// Define LCD_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_TOTAL       = DEF_H_TOTAL,
  parameter int H_SYNC_W      = DEF_H_SYNC_W,
  parameter int H_ACT_START   = DEF_H_ACT_START,
  parameter int V_TOTAL       = DEF_V_TOTAL,
  parameter int V_SYNC_W      = DEF_V_SYNC_W,
  parameter int V_ACT_START   = DEF_V_ACT_START,
  parameter int CLK_DIV       = 2,
  parameter int WARMUP_FRAMES = 2,
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int V_ACTIVE      = DEF_V_ACTIVE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [H_CNT_W-1:0] counter_h,
  output logic [V_CNT_W-1:0] counter_v,
  output logic               hsync,
  output logic               vsync,
  output logic               den,
  output logic               dclk,
  output logic               disp_enb
`ifdef LCD_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt
`endif
);

  localparam logic [H_CNT_W-1:0] H_LAST      = H_CNT_W'(H_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_LAST      = V_CNT_W'(V_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] H_SYNC_END  = H_CNT_W'(H_SYNC_W);
  localparam logic [V_CNT_W-1:0] V_SYNC_END  = V_CNT_W'(V_SYNC_W);
  localparam logic [H_CNT_W-1:0] H_ACT_FIRST = H_CNT_W'(H_ACT_START);
  localparam logic [H_CNT_W-1:0] H_ACT_LAST  = H_CNT_W'(H_ACT_START + H_ACTIVE - 1);
  localparam logic [V_CNT_W-1:0] V_ACT_FIRST = V_CNT_W'(V_ACT_START);
  localparam logic [V_CNT_W-1:0] V_ACT_LAST  = V_CNT_W'(V_ACT_START + V_ACTIVE - 1);
  localparam logic [7:0]         WARM_LAST   = 8'(WARMUP_FRAMES - 1);
  localparam logic [1:0]         ST_ENABLED  = (WARMUP_FRAMES == 0) ? ST_RUN : ST_WARMUP;

  logic [1:0]         state_q, state_d;
  logic [7:0]         warm_q, warm_d;
  logic [H_CNT_W-1:0] h_q, h_d;
  logic [V_CNT_W-1:0] v_q, v_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               den_q, den_d;
  logic               disp_q, disp_d;
  logic               tick;
  logic               eof;
  logic               run;
  logic               dclk_int;

  assign eof = tick && (h_q == H_LAST) && (v_q == V_LAST);
  assign run = (state_d != ST_IDLE);

  lcd_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick),
    .dclk (dclk_int)
  );

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    case (state_q)
      ST_IDLE: begin
        warm_d = 8'd0;
        if (en) begin
          state_d = ST_ENABLED;
        end
      end
      ST_WARMUP: begin
        if (eof) begin
          if (warm_q == WARM_LAST) begin
            state_d = ST_RUN;
          end else begin
            warm_d = warm_q + 8'd1;
          end
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
    // Dropping en always wins, from any state, at the very next edge.
    if (!en) begin
      state_d = ST_IDLE;
      warm_d  = 8'd0;
    end
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (state_d == ST_IDLE) begin
      h_d = '0;
      v_d = '0;
    end else if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Decode from next-state counters so registered syncs/den line up with the counters.
  always_comb begin
    hsync_d = (state_d == ST_IDLE) || (h_d >= H_SYNC_END);
    vsync_d = (state_d == ST_IDLE) || (v_d >= V_SYNC_END);
    den_d   = (state_d == ST_RUN) &&
              (h_d >= H_ACT_FIRST) && (h_d <= H_ACT_LAST) &&
              (v_d >= V_ACT_FIRST) && (v_d <= V_ACT_LAST);
    disp_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      warm_q  <= 8'd0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      den_q   <= 1'b0;
      disp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      den_q   <= den_d;
      disp_q  <= disp_d;
    end
  end

`ifdef LCD_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if ((state_q == ST_RUN) && eof) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign counter_h = h_q;
  assign counter_v = v_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign den       = den_q;
  assign dclk      = dclk_int;
  assign disp_enb  = disp_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen on a scaled-down 24x10 raster (active 12x5, CLK_DIV=2).
// Expected snapshots/counts are queued with a target cycle; a monitor compares them.
module tb_lcd_timing_gen;

  localparam int HT  = 24;
  localparam int HSW = 3;
  localparam int HAS = 6;
  localparam int HAW = 12;
  localparam int VT  = 10;
  localparam int VSW = 2;
  localparam int VAS = 3;
  localparam int VAW = 5;
  localparam int DIV = 2;
  localparam int WF  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [10:0] counter_h;
  logic [9:0]  counter_v;
  logic        hsync, vsync, den, dclk, disp_enb;
`ifdef LCD_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  lcd_timing_gen #(
    .H_TOTAL       (HT),
    .H_SYNC_W      (HSW),
    .H_ACT_START   (HAS),
    .V_TOTAL       (VT),
    .V_SYNC_W      (VSW),
    .V_ACT_START   (VAS),
    .CLK_DIV       (DIV),
    .WARMUP_FRAMES (WF),
    .H_ACTIVE      (HAW),
    .V_ACTIVE      (VAW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .counter_h (counter_h),
    .counter_v (counter_v),
    .hsync     (hsync),
    .vsync     (vsync),
    .den       (den),
    .dclk      (dclk),
    .disp_enb  (disp_enb)
`ifdef LCD_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {K_SNAP, K_CLR, K_CNT, K_PERIOD, K_FC} kind_e;
  typedef struct {
    kind_e kind;
    int    at;
    string name;
    int    h, v, hs, vs, dn, dc, de;
    int    id;
    int    exp;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad   = 0;
  int    meas[4];
  int    last_start = -1;
  int    period = 0;

  task automatic push_snap(input string nm, input int at, input int h, input int v,
                           input int hs, input int vs, input int dn, input int dc, input int de);
    item_t it;
    it.kind = K_SNAP; it.at = at; it.name = nm;
    it.h = h; it.v = v; it.hs = hs; it.vs = vs; it.dn = dn; it.dc = dc; it.de = de;
    it.id = 0; it.exp = 0;
    sb.push_back(it);
  endtask

  // Snapshot on the first clk cycle of linear pixel p (dclk low, panel enabled).
  task automatic push_pix(input string nm, input int r, input int p, input int h, input int v,
                          input int hs, input int vs, input int dn);
    push_snap(nm, r + 2 * p - 1, h, v, hs, vs, dn, 0, 1);
  endtask

  task automatic push_cnt(input kind_e k, input string nm, input int at, input int id, input int exp);
    item_t it;
    it.kind = k; it.at = at; it.name = nm;
    it.h = 0; it.v = 0; it.hs = 0; it.vs = 0; it.dn = 0; it.dc = 0; it.de = 0;
    it.id = id; it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic check(input item_t it);
    int act;
    total++;
    case (it.kind)
      K_SNAP: begin
        if (int'(counter_h) != it.h || int'(counter_v) != it.v || int'(hsync) != it.hs ||
            int'(vsync) != it.vs || int'(den) != it.dn || int'(dclk) != it.dc ||
            int'(disp_enb) != it.de) begin
          bad++;
          $display("FAIL %s @%0d: got h=%0d v=%0d hs=%0d vs=%0d den=%0d dclk=%0d disp=%0d want h=%0d v=%0d hs=%0d vs=%0d den=%0d dclk=%0d disp=%0d",
                   it.name, cyc, counter_h, counter_v, hsync, vsync, den, dclk, disp_enb,
                   it.h, it.v, it.hs, it.vs, it.dn, it.dc, it.de);
        end else begin
          $display("ok   %s @%0d: h=%0d v=%0d hs=%0d vs=%0d den=%0d dclk=%0d disp=%0d",
                   it.name, cyc, counter_h, counter_v, hsync, vsync, den, dclk, disp_enb);
        end
      end
      default: begin
        act = 0;
        if (it.kind == K_CNT) act = meas[it.id];
        else if (it.kind == K_PERIOD) act = period;
`ifdef LCD_TIMING_FRAME_CNT_EN
        else if (it.kind == K_FC) act = int'(frame_cnt);
`endif
        if (act != it.exp) begin
          bad++;
          $display("FAIL %s @%0d: got %0d want %0d", it.name, cyc, act, it.exp);
        end else begin
          $display("ok   %s @%0d: %0d", it.name, cyc, act);
        end
      end
    endcase
  endtask

  // Monitor: clears, accumulates, then compares everything due on this cycle.
  initial begin
    item_t keep[$];
    foreach (meas[i]) meas[i] = 0;
    forever begin
      @(negedge clk);
      foreach (sb[i]) if (sb[i].at == cyc && sb[i].kind == K_CLR) meas[sb[i].id] = 0;
      if (!hsync) meas[0]++;
      if (den)    meas[1]++;
      if (!vsync) meas[2]++;
      if (den)    meas[3]++;
      if (disp_enb && counter_h == 11'd0 && counter_v == 10'd0 && !dclk) begin
        if (last_start >= 0) period = cyc - last_start;
        last_start = cyc;
      end
      keep.delete();
      foreach (sb[i]) begin
        if (sb[i].at < cyc) begin
          total++;
          bad++;
          $display("FAIL %s: stale expectation for cycle %0d seen at %0d", sb[i].name, sb[i].at, cyc);
        end else if (sb[i].at == cyc) begin
          if (sb[i].kind != K_CLR) check(sb[i]);
        end else begin
          keep.push_back(sb[i]);
        end
      end
      sb = keep;
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int r, r2;
    rst = 1'b0;
    en  = 1'b1;
    push_snap("reset_idle", 4, 0, 0, 1, 1, 0, 0, 0);
    wait_until(5);
    rst = 1'b1;
    r  = cyc + 1;
    r2 = r + 2188;

    push_snap("rel_edge0", r, 0, 0, 0, 0, 0, 1, 1);
    push_pix("p1_first_tick",   r, 1,   1,  0, 0, 0, 0);
    push_pix("p3_hsync_end",    r, 3,   3,  0, 1, 0, 0);
    push_pix("warm0_act_pos",   r, 78,  6,  3, 1, 1, 0);
    push_pix("warm1_act_pos",   r, 318, 6,  3, 1, 1, 0);
    push_pix("run_v1_h0",       r, 504, 0,  1, 0, 0, 0);
    push_pix("run_v2_vs_end",   r, 538, 10, 2, 1, 1, 0);
    push_pix("run_h5_pre_act",  r, 557, 5,  3, 1, 1, 0);
    push_pix("run_h6_act_on",   r, 558, 6,  3, 1, 1, 1);
    push_snap("run_h6_dclk_hi", r + 2 * 558, 6, 3, 1, 1, 1, 1, 1);
    push_pix("run_h17_act_end", r, 569, 17, 3, 1, 1, 1);
    push_pix("run_h18_act_off", r, 570, 18, 3, 1, 1, 0);
    push_pix("run_v7_last_act", r, 658, 10, 7, 1, 1, 1);
    push_pix("run_v8_post_act", r, 682, 10, 8, 1, 1, 0);
    push_pix("run_frame_last",  r, 719, 23, 9, 1, 1, 0);
    push_pix("run_frame_wrap",  r, 720, 0,  0, 0, 0, 0);

    push_cnt(K_CLR, "clr_warm", r, 1, 0);
    push_cnt(K_CNT, "warmup_den_cycles", r + 958, 1, 0);
    push_cnt(K_CLR, "clr_frame_den", r + 959, 1, 0);
    push_cnt(K_CLR, "clr_frame_vs", r + 959, 2, 0);
    push_cnt(K_CNT, "frame_vs_low_cycles", r + 1438, 2, VSW * HT * DIV);
    push_cnt(K_CNT, "frame_den_cycles", r + 1438, 1, VAW * HAW * DIV);
    push_cnt(K_CLR, "clr_line_hs", r + 1103, 0, 0);
    push_cnt(K_CLR, "clr_line_den", r + 1103, 3, 0);
    push_cnt(K_CNT, "line_hs_low_cycles", r + 1150, 0, HSW * DIV);
    push_cnt(K_CNT, "line_den_cycles", r + 1150, 3, HAW * DIV);
    push_cnt(K_PERIOD, "frame_period", r + 1439, 0, HT * VT * DIV);

`ifdef LCD_TIMING_FRAME_CNT_EN
    push_cnt(K_FC, "fc_warmup", r + 958, 0, 0);
    push_cnt(K_FC, "fc_after_run1", r + 1500, 0, 1);
    push_cnt(K_FC, "fc_forced", r + 1700, 0, 65535);
    push_cnt(K_FC, "fc_wrap", r + 1930, 0, 0);
`endif

    push_pix("pre_disable", r, 1092, 12, 5, 1, 1, 1);
    push_snap("dis_idle", r + 2184, 0, 0, 1, 1, 0, 0, 0);
    push_snap("dis_hold", r + 2186, 0, 0, 1, 1, 0, 0, 0);
    push_snap("re_edge0", r2, 0, 0, 0, 0, 0, 1, 1);
    push_snap("re_p1", r2 + 1, 1, 0, 0, 0, 0, 0, 1);
    push_pix("re_warm_pos", r2, 132, 12, 5, 1, 1, 0);
    push_snap("async_rst", r2 + 300, 0, 0, 1, 1, 0, 0, 0);

`ifdef LCD_TIMING_FRAME_CNT_EN
    wait_until(r + 1600);
    force dut.frame_cnt_q = 16'hFFFF;
    wait_until(r + 1601);
    release dut.frame_cnt_q;
`endif

    wait_until(r + 2183);
    en = 1'b0;
    wait_until(r + 2187);
    en = 1'b1;

    wait_until(r2 + 299);
    @(posedge clk);
    #1 rst = 1'b0;

    wait_until(r2 + 305);
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 SHALL have parameter H_TOTAL, default 1056, meaning horizontal period in pixel clocks.
REQ-002 SHALL have parameter H_SYNC_W, default 20, meaning hsync low width in pixel clocks.
REQ-003 SHALL have parameter H_ACT_START, default 211, meaning first active counter_h value (800 active pixels).
REQ-004 SHALL have parameter V_TOTAL, default 525, meaning vertical period in lines.
REQ-005 SHALL have parameter V_SYNC_W, default 10, meaning vsync low width in lines.
REQ-006 SHALL have parameter V_ACT_START, default 23, meaning first active counter_v value (480 active lines).
REQ-007 SHALL have parameter CLK_DIV, default 2 (legal values 2..8), meaning clk cycles per pixel.
REQ-008 SHALL have parameter WARMUP_FRAMES, default 2, meaning full frames before den is released.
REQ-009 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-010 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-011 SHALL have port en, input, 1 bit, meaning run request.
REQ-012 SHALL have port counter_h, output, 11 bits, meaning horizontal pixel position.
REQ-013 SHALL have port counter_v, output, 10 bits, meaning vertical line position.
REQ-014 SHALL have ports hsync and vsync, outputs, 1 bit each, active-low syncs.
REQ-015 SHALL have port den, output, 1 bit, meaning data enable.
REQ-016 SHALL have ports dclk and disp_enb, outputs, 1 bit each, meaning pixel clock and panel enable.

Function
REQ-017 SHALL assert a pixel tick once every CLK_DIV clk cycles while not in IDLE; dclk SHALL be low for the first CLK_DIV/2 cycles of each pixel period and high for the rest.
REQ-018 SHALL advance counter_h by 1 on each tick, wrap at H_TOTAL-1 to 0, and increment counter_v on that same wrap.
REQ-019 SHALL wrap counter_v from V_TOTAL-1 to 0 on a simultaneous h-wrap/v-last tick; that is the end-of-frame event.
REQ-020 SHALL drive hsync low when counter_h < H_SYNC_W, and vsync low when counter_v < V_SYNC_W.
REQ-021 SHALL drive den high when counter_h is in [H_ACT_START, H_ACT_START+799], counter_v is in [V_ACT_START, V_ACT_START+479], and the state is RUN.
REQ-022 SHALL register all outputs so they are mutually aligned with the counter values of the same tick (zero skew between counters and syncs/den).
REQ-023 SHALL implement FSM states IDLE, WARMUP and RUN.
REQ-024 SHALL transition IDLE->WARMUP on en=1, WARMUP->RUN after WARMUP_FRAMES end-of-frame events, and any state->IDLE on en=0 at the next clk edge.
REQ-025 SHALL, in IDLE: zero counters and divider; hsync=1; vsync=1; den=0; dclk=0; disp_enb=0.
REQ-026 SHALL hold disp_enb high in WARMUP and RUN.
REQ-027 SHALL treat WARMUP_FRAMES=0 as entering RUN directly from IDLE.
REQ-028 SHALL restart from counter (0,0) on re-enable; a mid-frame en drop SHALL NOT resume the old position.

Reset
REQ-029 SHALL, while rst=0, force state IDLE and all outputs to IDLE values, with asynchronous assertion and release synchronous to clk.
REQ-030 SHALL, when rst rises with en=1, enter WARMUP on the first clk edge.

Configuration
REQ-031 SHALL, with LCD_TIMING_FRAME_CNT_EN defined, add output frame_cnt (16 bits), reset 0, incremented on every end-of-frame in RUN, wrapping 65535->0.
REQ-032 SHALL, without LCD_TIMING_FRAME_CNT_EN, omit the frame_cnt port and its logic entirely.

Structure
REQ-033 SHALL place FSM state encoding and default timing constants (1056/525/800/480) in shared package lcd_timing_pkg.
REQ-034 SHALL implement the pixel-tick/dclk divider as sub-module lcd_pix_div; counters, FSM and decode stay in the top level.

Verification
REQ-035 SHALL verify reset and release: rst=0 with en=1 -> all outputs at IDLE values; release rst -> disp_enb=1 on the next edge, and counter_h=1 after CLK_DIV cycles.
REQ-036 SHALL verify line timing: in RUN, hsync is low for exactly 20 ticks per 1056-tick line, and den is high for counter_h 211..1010 only.
REQ-037 SHALL verify frame timing: vsync is low for 10 lines, den is high for 480 lines (23..502), and a frame spans 1056*525*2 clk cycles.
REQ-038 SHALL verify warmup: den stays 0 for exactly 2 full frames after enable, then toggles on the third frame.
REQ-039 SHALL verify mid-frame disable: en=0 at (500,200) -> IDLE next edge, counters 0; en=1 -> WARMUP restarting at (0,0).
REQ-040 SHALL verify the macro build: with LCD_TIMING_FRAME_CNT_EN defined, frame_cnt increments by 1 per RUN frame; force 65535 -> next frame 0.
